// File: rtl/wb_ifetch_pkg.sv
// Shared types and constants for the Wishbone instruction-fetch block.
// Latency: none (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam logic        ST_IDLE    = 1'b0;
    localparam logic        ST_REQ     = 1'b1;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    typedef enum logic {
        IDLE = ST_IDLE,
        REQ  = ST_REQ
    } fetch_state_t;

    // One fetch-queue entry: the byte PC and the word fetched from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/wb_ifetch_if.sv
// Classic-cycle Wishbone read bus between the fetch master and the ROM slave.
// Latency: none (wires only).
// Backpressure: the slave stalls the master by withholding ack.
// Signals: cyc/stb/we/sel/dat_w/adr master->slave, dat_r/ack slave->master.
interface wb_ifetch_if #(
    parameter int ADDR_W = 10
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [31:0]       dat_w;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_r;
    logic              ack;

    modport master (
        output cyc, stb, we, sel, dat_w, adr,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, dat_w, adr,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_ifetch_fetch_queue.sv
// Generic synchronous FIFO used as the fetch queue.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush wins.
// Ports: clk_i/rst_i, push/push_dat, pop, flush, head_dat, count, full, empty.
module fetch_queue #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    // An empty queue presents zeros rather than a stale entry.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/wb_ifetch.sv
// Instruction-fetch Wishbone master: holds the PC, reads the ROM, queues {pc,inst} for decode.
// Latency: stb rises cycle N, ack N+1, instruction valid to decode N+2; 1 word / 2 cycles steady.
// Backpressure: a read is only issued with a free queue slot; decode stalls via inst_ready_i.
// Ports: clk_i/rst_i, wb (master modport), redirect_i/redirect_pc_i, inst_valid_o/inst_ready_i/inst_o/inst_pc_o.
module wb_ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10,
    parameter int          QDEPTH   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_ifetch_if.master         wb,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [31:0]         inst_o,
    output logic [31:0]         inst_pc_o
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pc_inc;
    logic [31:0]       redirect_tgt;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] adr_q, adr_d;

    logic              push;
    logic              pop;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     count_after;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      push_ent;
    fetch_entry_t      head_ent;

    assign redirect_tgt = redirect_pc_i & ~32'h3;
    assign pc_inc       = pc_q + 32'd4;
    assign pop          = inst_valid_o && inst_ready_i;
    // Occupancy after this cycle's push (only consulted when pushing).
    assign count_after  = q_count + CW'(1) - CW'(pop);
    assign push_ent     = '{pc: pc_q, inst: wb.dat_r};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        adr_d     = adr_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                end else if (!q_full) begin
                    state_d = REQ;
                    adr_d   = pc_q[ADDR_W+1:2];
                end
            end
            REQ: begin
                if (wb.ack) begin
                    if (discard_q) begin
                        // Ack of a cycle that was redirected away: drop the data.
                        discard_d = 1'b0;
                        state_d   = IDLE;
                        if (redirect_i) begin
                            pc_d = redirect_tgt;
                        end
                    end else if (redirect_i) begin
                        pc_d    = redirect_tgt;
                        state_d = IDLE;
                    end else begin
                        push = 1'b1;
                        pc_d = pc_inc;
                        if (count_after < CW'(QDEPTH)) begin
                            // Back-to-back: keep stb high, step the address now.
                            adr_d = pc_inc[ADDR_W+1:2];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_i) begin
                    // The bus cycle in flight must complete unchanged; its data is dropped.
                    pc_d      = redirect_tgt;
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            adr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            adr_q     <= adr_d;
        end
    end

    assign wb.cyc   = (state_q == REQ);
    assign wb.stb   = (state_q == REQ);
    assign wb.we    = 1'b0;
    assign wb.sel   = WB_SEL_ALL;
    assign wb.dat_w = '0;
    assign wb.adr   = adr_q;

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (redirect_i),
        .head_dat (head_ent),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign inst_valid_o = !q_empty;
    assign inst_o       = head_ent.inst;
    assign inst_pc_o    = head_ent.pc;
endmodule

// File: tb/tb_wb_ifetch.sv
// Self-checking bench for wb_ifetch with a registered-ack ROM model (mem[i]=A0000000+i).
// Latency: n/a.
// Backpressure: the bench drives inst_ready_i directly.
module tb_wb_ifetch;
    import ifetch_pkg::*;

    localparam int          ADDR_W   = 10;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b1;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;
    bit started    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    wb_ifetch_if #(.ADDR_W(ADDR_W)) bus ();

    wb_ifetch #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wb            (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (ready),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc)
    );

    // ROM slave: ack registered, high for exactly one cycle per strobe.
    always @(posedge clk) begin
        if (rst) begin
            bus.ack   <= 1'b0;
            bus.dat_r <= 32'h0;
        end else begin
            bus.ack   <= bus.cyc && bus.stb && !bus.ack;
            bus.dat_r <= 32'hA000_0000 + 32'(bus.adr);
        end
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [ADDR_W-1:0] w;
        w = pc[ADDR_W+1:2];
        return 32'hA000_0000 + 32'(w);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Stream model: after reset or redirect the delivered PCs run T, T+4, ...
    // and each word is the ROM content of its PC; stalled heads stay put and
    // redirects/resets empty the queue.
    logic [31:0] exp_pc = RESET_PC;
    logic        prev_hold = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_inst = 32'h0;
    logic [31:0] prev_pc = 32'h0;

    always @(negedge clk) begin
        if (started) begin
            check32("cyc_eq_stb", {31'b0, bus.cyc}, {31'b0, bus.stb});
            check32("we_zero", {31'b0, bus.we}, 32'h0);
            check32("sel_all", {28'b0, bus.sel}, {28'b0, WB_SEL_ALL});
            check32("dat_o_zero", bus.dat_w, 32'h0);
            if (prev_hold) begin
                check32("hold_valid", {31'b0, inst_valid}, 32'h1);
                check32("hold_inst", inst, prev_inst);
                check32("hold_pc", inst_pc, prev_pc);
            end
            if (prev_flush) begin
                check32("flush_valid", {31'b0, inst_valid}, 32'h0);
            end
            if (inst_valid && ready) begin
                check32("stream_pc", inst_pc, exp_pc);
                check32("stream_inst", inst, rom_word(inst_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) exp_pc = redirect_pc & ~32'h3;
            if (rst) exp_pc = RESET_PC;
            prev_hold  = inst_valid && !ready && !redirect && !rst;
            prev_flush = redirect || rst;
            prev_inst  = inst;
            prev_pc    = inst_pc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        step();
        started = 1'b1;
        step();
    endtask

    task automatic wait_accept(output logic [31:0] pc, output logic [31:0] w, output int cyc);
        int n = 0;
        while (!(inst_valid && ready) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) timeout_fail("wait_accept");
        pc  = inst_pc;
        w   = inst;
        cyc = cycle;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p0, p1, p2, w0, w1, w2;
        int c0, c1, c2, acks, n;

        // Reset state, then a straight run with decode always ready.
        ready = 1'b1;
        do_reset();
        check32("rst_stb", {31'b0, bus.stb}, 32'h0);
        check32("rst_cyc", {31'b0, bus.cyc}, 32'h0);
        check32("rst_valid", {31'b0, inst_valid}, 32'h0);
        check32("rst_inst", inst, 32'h0);
        check32("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        step();
        check32("first_stb", {31'b0, bus.stb}, 32'h1);
        check32("first_adr", {22'b0, bus.adr}, 32'h0);
        step();
        check32("first_ack", {31'b0, bus.ack}, 32'h1);
        check32("first_valid_early", {31'b0, inst_valid}, 32'h0);
        step();
        check32("first_valid", {31'b0, inst_valid}, 32'h1);
        wait_accept(p0, w0, c0);
        wait_accept(p1, w1, c1);
        wait_accept(p2, w2, c2);
        check32("run_pc0", p0, 32'h0);
        check32("run_w0", w0, 32'hA000_0000);
        check32("run_pc1", p1, 32'h4);
        check32("run_w1", w1, 32'hA000_0001);
        check32("run_pc2", p2, 32'h8);
        check32("run_w2", w2, 32'hA000_0002);
        check32("spacing01", 32'(c1 - c0), 32'd2);
        check32("spacing12", 32'(c2 - c1), 32'd2);

        // Decode stalled: the queue fills with exactly QDEPTH words.
        do_reset();
        ready = 1'b0;
        rst   = 1'b0;
        acks  = 0;
        repeat (20) begin
            step();
            if (bus.ack) acks++;
        end
        check32("stall_acks", 32'(acks), 32'd2);
        check32("stall_cyc", {31'b0, bus.cyc}, 32'h0);
        check32("stall_valid", {31'b0, inst_valid}, 32'h1);
        check32("stall_head_inst", inst, 32'hA000_0000);
        check32("stall_head_pc", inst_pc, 32'h0);
        ready = 1'b1;
        wait_accept(p0, w0, c0);
        wait_accept(p1, w1, c1);
        wait_accept(p2, w2, c2);
        check32("resume_pc0", p0, 32'h0);
        check32("resume_pc1", p1, 32'h4);
        check32("resume_pc2", p2, 32'h8);
        check32("resume_w2", w2, 32'hA000_0002);

        // Redirect while the strobe waits for ack: the in-flight word is dropped.
        do_reset();
        ready = 1'b1;
        rst   = 1'b0;
        step();
        check32("rd1_stb", {31'b0, bus.stb}, 32'h1);
        check32("rd1_noack", {31'b0, bus.ack}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        check32("rd1_stb_held", {31'b0, bus.stb}, 32'h1);
        check32("rd1_adr_held", {22'b0, bus.adr}, 32'h0);
        check32("rd1_ack", {31'b0, bus.ack}, 32'h1);
        step();
        check32("rd1_dropped", {31'b0, inst_valid}, 32'h0);
        check32("rd1_idle", {31'b0, bus.stb}, 32'h0);
        wait_accept(p0, w0, c0);
        check32("rd1_pc", p0, 32'h0000_0100);
        check32("rd1_w", w0, 32'hA000_0040);

        // Redirect in the cycle of an ack, with a word already queued.
        do_reset();
        ready = 1'b0;
        rst   = 1'b0;
        n     = 0;
        while (!(bus.ack && inst_valid) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) timeout_fail("rd2_wait_ack");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        check32("rd2_flushed", {31'b0, inst_valid}, 32'h0);
        check32("rd2_idle", {31'b0, bus.stb}, 32'h0);
        ready = 1'b1;
        wait_accept(p0, w0, c0);
        check32("rd2_pc", p0, 32'h0000_0200);
        check32("rd2_w", w0, 32'hA000_0080);

        // Redirect from IDLE to the last ROM word: address wraps to 0.
        do_reset();
        ready       = 1'b1;
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0FFC;
        step();
        redirect = 1'b0;
        check32("rd3_stay_idle", {31'b0, bus.stb}, 32'h0);
        step();
        check32("rd3_stb", {31'b0, bus.stb}, 32'h1);
        check32("rd3_adr", {22'b0, bus.adr}, 32'h0000_03FF);
        wait_accept(p0, w0, c0);
        wait_accept(p1, w1, c1);
        check32("rd3_pc0", p0, 32'h0000_0FFC);
        check32("rd3_w0", w0, 32'hA000_03FF);
        check32("rd3_pc1", p1, 32'h0000_1000);
        check32("rd3_w1", w1, 32'hA000_0000);

        // PC wraps modulo 2^32; low target bits are ignored.
        do_reset();
        ready       = 1'b1;
        rst         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        wait_accept(p0, w0, c0);
        wait_accept(p1, w1, c1);
        check32("wrap_pc0", p0, 32'hFFFF_FFFC);
        check32("wrap_w0", w0, 32'hA000_03FF);
        check32("wrap_pc1", p1, 32'h0000_0000);
        check32("wrap_w1", w1, 32'hA000_0000);

        // Reset asserted in the ack cycle.
        do_reset();
        ready = 1'b1;
        rst   = 1'b0;
        step();
        step();
        check32("rst_mid_ack", {31'b0, bus.ack}, 32'h1);
        rst = 1'b1;
        step();
        check32("rst_mid_cyc", {31'b0, bus.cyc}, 32'h0);
        check32("rst_mid_stb", {31'b0, bus.stb}, 32'h0);
        check32("rst_mid_valid", {31'b0, inst_valid}, 32'h0);
        rst = 1'b0;
        step();
        check32("rst_mid_restart", {31'b0, bus.stb}, 32'h1);
        check32("rst_mid_adr", {22'b0, bus.adr}, 32'h0);
        wait_accept(p0, w0, c0);
        check32("rst_mid_pc", p0, RESET_PC);
        check32("rst_mid_w", w0, 32'hA000_0000);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
